// File: rtl/vrb_pkg.sv
// Shared types for the vrb two-master arbiter: state encoding and the
// latched command record that is replayed to the slave while a grant is held.
package vrb_pkg;

  localparam int VRB_AW = 32;
  localparam int VRB_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [VRB_AW-1:0]   addr;
    logic                read;
    logic [VRB_DW-1:0]   wdata;
    logic [VRB_DW/8-1:0] wmask;
  } vrb_cmd_t;

  // Map a grant id onto the matching ownership state.
  function automatic arb_state_t own_state(input logic id);
    return id ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/vrb_rr_pick.sv
// Two-way request picker: a lone requester always wins; on a tie either
// master 1 wins outright (prio_m1) or the master that was not granted last.
module vrb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       prio_m1,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Select the winner and produce a one-hot grant plus its index.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        if (prio_m1) begin
          gnt_id = 1'b1;
        end else begin
          gnt_id = ~last_gnt;
        end
        gnt = gnt_id ? 2'b10 : 2'b01;
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vrb_arb2.sv
// Two-master (IFU / LSU) to one-slave arbiter for the vrb bus. The grant is
// held from command until slave response, the command is latched so a master
// may flush or change its request without disturbing the outstanding access,
// and a watchdog converts a hung slave into an error response.
// The cmd_q record uses the package widths, so AW/DW must match VRB_AW/VRB_DW.
module vrb_arb2
  import vrb_pkg::*;
#(
  parameter int AW      = VRB_AW,
  parameter int DW      = VRB_DW,
  parameter int PRIO_M1 = 0,
  parameter int TMO_CYC = 255,
  parameter int CW      = 8
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            i_m0_cmd_valid,
  input  logic [AW-1:0]   i_m0_cmd_addr,
  input  logic            i_m0_cmd_read,
  input  logic [DW-1:0]   i_m0_cmd_wdata,
  input  logic [DW/8-1:0] i_m0_cmd_wmask,
  output logic            o_m0_rsp_valid,
  output logic            o_m0_rsp_err,
  output logic [DW-1:0]   o_m0_rsp_rdata,

  input  logic            i_m1_cmd_valid,
  input  logic [AW-1:0]   i_m1_cmd_addr,
  input  logic            i_m1_cmd_read,
  input  logic [DW-1:0]   i_m1_cmd_wdata,
  input  logic [DW/8-1:0] i_m1_cmd_wmask,
  output logic            o_m1_rsp_valid,
  output logic            o_m1_rsp_err,
  output logic [DW-1:0]   o_m1_rsp_rdata,

  output logic            o_s_cmd_valid,
  output logic [AW-1:0]   o_s_cmd_addr,
  output logic            o_s_cmd_read,
  output logic [DW-1:0]   o_s_cmd_wdata,
  output logic [DW/8-1:0] o_s_cmd_wmask,
  input  logic            i_s_rsp_valid,
  input  logic            i_s_rsp_err,
  input  logic [DW-1:0]   i_s_rsp_rdata,

  output logic            o_busy,
  output logic            o_tmo
);

  localparam logic [CW-1:0] TMO_VAL  = CW'(TMO_CYC);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic          TMO_EN   = (TMO_CYC != 0);
  localparam logic          PRIO_BIT = (PRIO_M1 != 0);

  arb_state_t     state_r;
  logic           last_gnt_r;
  vrb_cmd_t       cmd_q_r;
  logic [CW-1:0]  tmo_cnt_r;

  vrb_cmd_t       m0_cmd_s;
  vrb_cmd_t       m1_cmd_s;
  vrb_cmd_t       win_cmd_s;
  vrb_cmd_t       s_cmd_s;
  logic [1:0]     req_s;
  logic [1:0]     gnt_s;
  logic           gnt_id_s;
  logic           s_cmd_valid_s;
  logic           owner_s;
  logic           route_s;
  logic           tmo_fire_s;
  logic           rsp_err_s;
  logic [DW-1:0]  rsp_rdata_s;

  assign m0_cmd_s = '{addr: i_m0_cmd_addr, read: i_m0_cmd_read,
                      wdata: i_m0_cmd_wdata, wmask: i_m0_cmd_wmask};
  assign m1_cmd_s = '{addr: i_m1_cmd_addr, read: i_m1_cmd_read,
                      wdata: i_m1_cmd_wdata, wmask: i_m1_cmd_wmask};
  assign req_s     = {i_m1_cmd_valid, i_m0_cmd_valid};
  assign win_cmd_s = gnt_id_s ? m1_cmd_s : m0_cmd_s;

  vrb_rr_pick u_pick (
    .req      (req_s),
    .last_gnt (last_gnt_r),
    .prio_m1  (PRIO_BIT),
    .gnt      (gnt_s),
    .gnt_id   (gnt_id_s)
  );

  // Choose what the slave sees, who owns the bus, and whether a response
  // (real or watchdog) is delivered this cycle.
  always_comb begin
    s_cmd_s       = cmd_q_r;
    s_cmd_valid_s = 1'b0;
    owner_s       = 1'b0;
    route_s       = 1'b0;
    tmo_fire_s    = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (|gnt_s) begin
          s_cmd_s       = win_cmd_s;
          s_cmd_valid_s = 1'b1;
          owner_s       = gnt_id_s;
          route_s       = i_s_rsp_valid;
        end else begin
          s_cmd_s       = cmd_q_r;
          s_cmd_valid_s = 1'b0;
          route_s       = 1'b0;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        s_cmd_valid_s = 1'b1;
        owner_s       = (state_r == ARB_OWN1);
        if (i_s_rsp_valid) begin
          route_s = 1'b1;
        end else if (TMO_EN && (tmo_cnt_r == TMO_VAL)) begin
          route_s    = 1'b1;
          tmo_fire_s = 1'b1;
        end else begin
          route_s    = 1'b0;
          tmo_fire_s = 1'b0;
        end
      end
      default: begin
        s_cmd_valid_s = 1'b0;
        route_s       = 1'b0;
      end
    endcase
  end

  // A watchdog expiry returns an error with zeroed data; otherwise pass through.
  assign rsp_err_s   = tmo_fire_s ? 1'b1 : i_s_rsp_err;
  assign rsp_rdata_s = tmo_fire_s ? {DW{1'b0}} : i_s_rsp_rdata;

  assign o_s_cmd_valid  = ~rst & s_cmd_valid_s;
  assign o_s_cmd_addr   = s_cmd_s.addr;
  assign o_s_cmd_read   = s_cmd_s.read;
  assign o_s_cmd_wdata  = s_cmd_s.wdata;
  assign o_s_cmd_wmask  = s_cmd_s.wmask;

  assign o_m0_rsp_valid = ~rst & route_s & ~owner_s;
  assign o_m1_rsp_valid = ~rst & route_s & owner_s;
  assign o_m0_rsp_err   = o_m0_rsp_valid & rsp_err_s;
  assign o_m1_rsp_err   = o_m1_rsp_valid & rsp_err_s;
  assign o_m0_rsp_rdata = rsp_rdata_s;
  assign o_m1_rsp_rdata = rsp_rdata_s;

  assign o_busy = ~rst & (state_r != ARB_IDLE);
  assign o_tmo  = ~rst & tmo_fire_s;

  // Arbitration state machine: grant, latch the command, hold until response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ARB_IDLE;
      last_gnt_r <= 1'b1;
      cmd_q_r    <= '0;
      tmo_cnt_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (|gnt_s) begin
            cmd_q_r    <= win_cmd_s;
            last_gnt_r <= gnt_id_s;
            if (i_s_rsp_valid) begin
              state_r   <= ARB_IDLE;
              tmo_cnt_r <= {CW{1'b0}};
            end else begin
              state_r   <= own_state(gnt_id_s);
              tmo_cnt_r <= CNT_ONE;
            end
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_OWN0, ARB_OWN1: begin
          if (route_s) begin
            state_r   <= ARB_IDLE;
            tmo_cnt_r <= {CW{1'b0}};
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= ARB_IDLE;
          tmo_cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
